// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative (1 bit/cycle) MUL/DIV/REM.
// Latency: ops 0-9/illegal reach DONE on the accept edge; ops 10-17 spend XLEN cycles in BUSY.
// Backpressure: in_ready only in IDLE; DONE holds result/illegal until out_ready.
module alu_mc #(
    parameter int XLEN  = 32,
    parameter bit trace = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int SH = $clog2(XLEN);
    localparam int CW = SH + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [4:0]      op_q;
    logic [XLEN-1:0] hi, lo, mcand, a_raw;
    logic            neg_q, neg_r, dz;
    logic [CW-1:0]   cnt;

    logic accept, legal, is_md, is_div_in, is_div_q, last;
    assign accept    = in_valid && in_ready;
    assign legal     = (op <= 5'd17);
    assign is_md     = (op >= 5'd10) && legal;
    assign is_div_in = (op >= 5'd14);
    assign is_div_q  = (op_q >= 5'd14);
    assign last      = (cnt == CW'(XLEN - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (op)
            5'd0:    alu_res = op1 + op2;
            5'd1:    alu_res = op1 - op2;
            5'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            5'd4:    alu_res = op1 & op2;
            5'd5:    alu_res = op1 | op2;
            5'd6:    alu_res = op1 ^ op2;
            5'd7:    alu_res = op1 << op2[SH-1:0];
            5'd8:    alu_res = op1 >> op2[SH-1:0];
            5'd9:    alu_res = $signed(op1) >>> op2[SH-1:0];
            default: alu_res = '0;
        endcase
    end

    // Signed ops are run as unsigned magnitudes; signs are reapplied on the last step.
    logic            sa, sb, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    always_comb begin
        sa    = (op == 5'd11) || (op == 5'd12) || (op == 5'd14) || (op == 5'd16);
        sb    = (op == 5'd11) || (op == 5'd14) || (op == 5'd16);
        a_neg = sa && op1[XLEN-1];
        b_neg = sb && op2[XLEN-1];
        mag_a = a_neg ? -op1 : op1;
        mag_b = b_neg ? -op2 : op2;
    end

    // One shift-add (mul) or restoring-subtract (div) step per BUSY cycle.
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [XLEN-1:0] hi_nx, lo_nx;
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, mcand};
        if (is_div_q) begin
            if (!div_diff[XLEN]) begin
                hi_nx = div_diff[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = div_sh[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_nx, lo_nx} = {mul_sum, lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   md_res;
    always_comb begin
        prod   = {hi_nx, lo_nx};
        prod_f = neg_q ? -prod : prod;
        case (op_q)
            5'd10:        md_res = prod_f[XLEN-1:0];
            5'd11, 5'd12,
            5'd13:        md_res = prod_f[2*XLEN-1:XLEN];
            5'd14, 5'd15: md_res = dz ? '1 : (neg_q ? -lo_nx : lo_nx);
            default:      md_res = dz ? a_raw : (neg_r ? -hi_nx : hi_nx);
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = is_md ? BUSY : DONE;
            BUSY:    if (kill) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            result  <= '0;
            illegal <= 1'b0;
            cnt     <= '0;
            op_q    <= '0;
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            a_raw   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    op_q    <= op;
                    a_raw   <= op1;
                    cnt     <= '0;
                    illegal <= !legal;
                    hi      <= '0;
                    lo      <= is_div_in ? mag_a : mag_b;
                    mcand   <= is_div_in ? mag_b : mag_a;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    dz      <= (op2 == '0);
                    if (!is_md) result <= legal ? alu_res : '0;
                end
                BUSY: if (kill) begin
                    cnt <= '0;
                end else begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result  <= md_res;
                        illegal <= 1'b0;
                        cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (trace && !rst && accept)
            $display("alu_mc: op=%0d op1=%h op2=%h", op, op1, op2);
    end
`endif
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (XLEN=32) with a queue scoreboard checked by a separate monitor.
module tb_alu_mc;
    localparam int XLEN = 32;
    localparam int MDL  = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, kill, out_valid, out_ready, illegal;
    logic [4:0]      op;
    logic [XLEN-1:0] op1, op2, result;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(XLEN), .trace(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op1(op1), .op2(op2), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal)
    );

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            ill;
    } exp_t;
    exp_t  q[$];
    int    tests = 0;
    int    fails = 0;
    string cur = "reset";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk({cur, "_spurious_out_valid"}, 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk({cur, "_result"}, 64'(result), 64'(e.res));
                    chk({cur, "_illegal"}, 64'(illegal), 64'(e.ill));
                end
            end
        end
    end

    // lat = edges from the accept edge (counted as 1) until out_valid is seen.
    task automatic issue(input string nm, input logic [4:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] er, input logic ei,
                         input int lat, input bit hold, input bit k);
        int n;
        cur = nm;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; op1 = a; op2 = b; kill = k;
        if (hold) out_ready = 1'b0;
        q.push_back('{res: er, ill: ei});
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        if (hold) begin
            repeat (5) begin
                chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
                chk({nm, "_hold_result"}, 64'(result), 64'(er));
                chk({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({nm, "_idle_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin : stim
        bit seen;
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        op = '0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);

        issue("add",  5'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1, 0, 0);
        issue("sub",  5'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1, 0, 0);
        issue("slt",  5'd2, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1, 0, 0);
        issue("sltu", 5'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1, 0, 0);
        issue("and",  5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 0, 0);
        issue("or",   5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1, 0, 0);
        issue("xor",  5'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 0, 0);
        issue("sll",  5'd7, 32'd1,         32'd35,        32'd8,         1'b0, 1, 0, 0);
        issue("srl",  5'd8, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1, 0, 0);
        issue("sra",  5'd9, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1, 0, 0);

        issue("mul",    5'd10, 32'd6,         32'd7,         32'd42,        1'b0, MDL, 0, 0);
        issue("mul_m1", 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, MDL, 0, 0);
        issue("mulh",   5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0, MDL, 0, 0);
        issue("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MDL, 0, 0);
        issue("mulhu",  5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MDL, 1, 0);

        issue("div_ovf",  5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, MDL, 0, 0);
        issue("rem_ovf",  5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, MDL, 0, 0);
        issue("divu_dz",  5'd15, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, MDL, 0, 0);
        issue("remu_dz",  5'd17, 32'd5,         32'd0,         32'd5,         1'b0, MDL, 0, 0);
        issue("div_neg",  5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, MDL, 0, 0);
        issue("rem_neg",  5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, MDL, 0, 0);
        issue("div_sdz",  5'd14, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0, MDL, 0, 0);
        issue("rem_sdz",  5'd16, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, MDL, 0, 0);
        issue("divu",     5'd15, 32'd100,       32'd7,         32'd14,        1'b0, MDL, 0, 0);
        issue("remu",     5'd17, 32'd100,       32'd7,         32'd2,         1'b0, MDL, 0, 0);

        issue("illegal20", 5'd20, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1, 0, 0);
        issue("illegal31", 5'd31, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b1, 1, 0, 0);
        issue("add_kill",  5'd0,  32'd10,        32'd20, 32'd30, 1'b0, 1, 0, 1);

        // Kill a DIV in its 10th BUSY cycle.
        cur = "kill";
        @(posedge clk); #1;
        in_valid = 1'b1; op = 5'd14; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_in_ready", 64'(in_ready), 64'd1);
        chk("kill_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("kill_no_out_valid", 64'(seen), 64'd0);
        issue("sub_after_kill", 5'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 0, 0);

        // Reset pulse in the middle of a MUL.
        cur = "rst_mid_mul";
        @(posedge clk); #1;
        in_valid = 1'b1; op = 5'd10; op1 = 32'd6; op2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_result", 64'(result), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("rst_mid_no_out_valid", 64'(seen), 64'd0);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
